// File: rtl/arm_pkg.sv
// Shared fetch-path types and constants: word widths, PC step, default reset PC
// and the {pc, instr} entry carried through the fetch queue.
package arm_pkg;

  localparam int WORD_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [WORD_W-1:0] PC_STEP          = 32'd4;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Branch targets are forced onto a word boundary before loading the PC.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module fetch_fifo_mem
  import arm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: PC register plus a circular buffer of fetched
// {pc, instr} pairs feeding decode, with redirect flush on taken branches.
module fetch_queue
  import arm_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_enable,
  output logic [WORD_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_instr,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_target,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [INSTR_W-1:0]         deq_instr,
  output logic [WORD_W-1:0]          deq_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] pc_q;
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic              full;
  logic              enq;
  logic              deq;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head_entry;

  assign full      = (count_q == CW'(DEPTH));
  assign deq_valid = (count_q != '0) && !redirect;
  assign deq       = deq_valid && deq_ready;
  // A full queue may still fetch when the head leaves in the same cycle.
  assign enq       = fetch_enable && !redirect && (!full || deq);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = imem_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      pc_q    <= align_pc(redirect_target);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        tail_q <= tail_q + PW'(1);
        pc_q   <= pc_q + PC_STEP;
      end
      if (deq) head_q <= head_q + PW'(1);
      if (enq && !deq)      count_q <= count_q + CW'(1);
      else if (!enq && deq) count_q <= count_q - CW'(1);
    end
  end

  fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (head_entry)
  );

  assign imem_addr = pc_q;
  assign deq_instr = head_entry.instr;
  assign deq_pc    = head_entry.pc;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: default instance for run/fill/redirect/stream/
// freeze scenarios, second instance with a near-wrap RESET_PC for PC wrap and reset.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic        rst_a, fe_a, redir_a, dr_a;
  logic [31:0] tgt_a, imem_addr_a, imem_instr_a, deq_instr_a, deq_pc_a;
  logic        deq_valid_a;
  logic [2:0]  count_a;

  // wrap instance
  logic        rst_w, fe_w, redir_w, dr_w;
  logic [31:0] tgt_w, imem_addr_w, imem_instr_w, deq_instr_w, deq_pc_w;
  logic        deq_valid_w;
  logic [2:0]  count_w;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr_a = mem_word(imem_addr_a);
  assign imem_instr_w = mem_word(imem_addr_w);

  fetch_queue dut (
    .clk(clk), .reset(rst_a), .fetch_enable(fe_a), .imem_addr(imem_addr_a),
    .imem_instr(imem_instr_a), .redirect(redir_a), .redirect_target(tgt_a),
    .deq_ready(dr_a), .deq_valid(deq_valid_a), .deq_instr(deq_instr_a),
    .deq_pc(deq_pc_a), .count(count_a)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(rst_w), .fetch_enable(fe_w), .imem_addr(imem_addr_w),
    .imem_instr(imem_instr_w), .redirect(redir_w), .redirect_target(tgt_w),
    .deq_ready(dr_w), .deq_valid(deq_valid_w), .deq_instr(deq_instr_w),
    .deq_pc(deq_pc_w), .count(count_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across two edges, then releases it 1 time unit after an edge.
  task automatic reset_a(input logic fe, input logic dr);
    rst_a = 1'b0; fe_a = fe; dr_a = dr; redir_a = 1'b0; tgt_a = '0;
    step();
    step();
    rst_a = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; fe_a = 1'b1; dr_a = 1'b1; redir_a = 1'b0; tgt_a = '0;
    #2;
    checks++;
    if (deq_valid_a !== 1'b0 || count_a !== 3'd0 || imem_addr_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: valid=%b count=%0d addr=%h, want 0 0 00000000",
               deq_valid_a, count_a, imem_addr_a);
    end
    step();
    step();
    checks++;
    if (deq_valid_a !== 1'b0 || count_a !== 3'd0 || imem_addr_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_held: valid=%b count=%0d addr=%h, want 0 0 00000000",
               deq_valid_a, count_a, imem_addr_a);
    end
  endtask

  task automatic test_run();
    reset_a(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (deq_valid_a !== 1'b1 || deq_pc_a !== 32'(4*i) ||
          deq_instr_a !== mem_word(32'(4*i)) || count_a !== 3'd1) begin
        errors++;
        $display("FAIL run_%0d: valid=%b pc=%h instr=%h count=%0d, want 1 %h %h 1",
                 i, deq_valid_a, deq_pc_a, deq_instr_a, count_a, 32'(4*i), mem_word(32'(4*i)));
      end
    end
  endtask

  task automatic test_fill();
    int exp_cnt;
    reset_a(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      exp_cnt = (i + 1 > 4) ? 4 : i + 1;
      checks++;
      if (count_a !== 3'(exp_cnt)) begin
        errors++;
        $display("FAIL fill_count_%0d: count=%0d, want %0d", i, count_a, exp_cnt);
      end
    end
    checks++;
    if (imem_addr_a !== 32'h10) begin
      errors++;
      $display("FAIL fill_addr_hold: addr=%h, want 00000010", imem_addr_a);
    end
    dr_a = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (deq_valid_a !== 1'b1 || deq_pc_a !== 32'(4*i) || deq_instr_a !== mem_word(32'(4*i))) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b pc=%h instr=%h, want 1 %h %h",
                 i, deq_valid_a, deq_pc_a, deq_instr_a, 32'(4*i), mem_word(32'(4*i)));
      end
      step();
      checks++;
      if (count_a !== 3'd4) begin
        errors++;
        $display("FAIL drain_full_count_%0d: count=%0d, want 4", i, count_a);
      end
    end
  endtask

  task automatic test_redirect();
    reset_a(1'b1, 1'b0);
    step(); step(); step();
    checks++;
    if (count_a !== 3'd3 || imem_addr_a !== 32'hC) begin
      errors++;
      $display("FAIL redir_pre: count=%0d addr=%h, want 3 0000000c", count_a, imem_addr_a);
    end
    redir_a = 1'b1; tgt_a = 32'h0000_0026; dr_a = 1'b1;
    #1;
    checks++;
    if (deq_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL redir_valid_low: valid=%b, want 0", deq_valid_a);
    end
    step();
    redir_a = 1'b0;
    #1;
    checks++;
    if (count_a !== 3'd0 || imem_addr_a !== 32'h24 || deq_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: count=%0d addr=%h valid=%b, want 0 00000024 0",
               count_a, imem_addr_a, deq_valid_a);
    end
    step();
    checks++;
    if (deq_valid_a !== 1'b1 || deq_pc_a !== 32'h24 || deq_instr_a !== mem_word(32'h24)) begin
      errors++;
      $display("FAIL redir_first: valid=%b pc=%h instr=%h, want 1 00000024 %h",
               deq_valid_a, deq_pc_a, deq_instr_a, mem_word(32'h24));
    end
  endtask

  task automatic test_full_stream();
    reset_a(1'b1, 1'b0);
    step(); step(); step(); step();
    dr_a = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (count_a !== 3'd4 || deq_pc_a !== 32'(4*(i+1))) begin
        errors++;
        $display("FAIL stream_%0d: count=%0d pc=%h, want 4 %h", i, count_a, deq_pc_a, 32'(4*(i+1)));
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    rst_w = 1'b0; fe_w = 1'b1; dr_w = 1'b1; redir_w = 1'b0; tgt_w = '0;
    #1;
    checks++;
    if (imem_addr_w !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL wrap_reset_addr: addr=%h, want fffffff8", imem_addr_w);
    end
    step();
    rst_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (deq_valid_w !== 1'b1 || deq_pc_w !== exp_pc[i] || count_w !== 3'd1) begin
        errors++;
        $display("FAIL wrap_pc_%0d: valid=%b pc=%h count=%0d, want 1 %h 1",
                 i, deq_valid_w, deq_pc_w, count_w, exp_pc[i]);
      end
    end
    #2;
    rst_w = 1'b0;
    #1;
    checks++;
    if (deq_valid_w !== 1'b0 || count_w !== 3'd0 || imem_addr_w !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL wrap_midcycle_reset: valid=%b count=%0d addr=%h, want 0 0 fffffff8",
               deq_valid_w, count_w, imem_addr_w);
    end
    step();
    rst_w = 1'b1;
  endtask

  task automatic test_freeze();
    reset_a(1'b1, 1'b0);
    step(); step();
    fe_a = 1'b0; dr_a = 1'b1;
    #1;
    checks++;
    if (count_a !== 3'd2 || imem_addr_a !== 32'h8) begin
      errors++;
      $display("FAIL freeze_pre: count=%0d addr=%h, want 2 00000008", count_a, imem_addr_a);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (deq_valid_a !== 1'b1 || deq_pc_a !== 32'(4*i)) begin
        errors++;
        $display("FAIL freeze_head_%0d: valid=%b pc=%h, want 1 %h", i, deq_valid_a, deq_pc_a, 32'(4*i));
      end
      step();
      checks++;
      if (count_a !== 3'(1-i) || imem_addr_a !== 32'h8) begin
        errors++;
        $display("FAIL freeze_drain_%0d: count=%0d addr=%h, want %0d 00000008",
                 i, count_a, imem_addr_a, 1-i);
      end
    end
    step();
    checks++;
    if (count_a !== 3'd0 || deq_valid_a !== 1'b0 || imem_addr_a !== 32'h8) begin
      errors++;
      $display("FAIL freeze_empty: count=%0d valid=%b addr=%h, want 0 0 00000008",
               count_a, deq_valid_a, imem_addr_a);
    end
  endtask

  initial begin
    rst_w = 1'b0; fe_w = 1'b0; dr_w = 1'b0; redir_w = 1'b0; tgt_w = '0;
    test_reset();
    test_run();
    test_fill();
    test_redirect();
    test_full_stream();
    test_wrap_reset();
    test_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
